// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// codes, special decode values and the output FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] VAL_BLANK = 4'hF;
  localparam logic [3:0] VAL_ERR   = 4'hE;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Observed scan bus (an/seg) plus the decoded-frame valid/ready handshake.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    frame_ready;
  logic                    frame_valid;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    overflow;

  modport master (
    output an, seg, frame_ready,
    input  frame_valid, digits, digit_err, overflow
  );

  modport slave (
    input  an, seg, frame_ready,
    output frame_valid, digits, digit_err, overflow
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to digit value decoder.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    value = VAL_ERR;
    err   = 1'b1;
    case (pattern)
      SEG_0:     begin value = 4'd0;      err = 1'b0; end
      SEG_1:     begin value = 4'd1;      err = 1'b0; end
      SEG_2:     begin value = 4'd2;      err = 1'b0; end
      SEG_3:     begin value = 4'd3;      err = 1'b0; end
      SEG_4:     begin value = 4'd4;      err = 1'b0; end
      SEG_5:     begin value = 4'd5;      err = 1'b0; end
      SEG_6:     begin value = 4'd6;      err = 1'b0; end
      SEG_7:     begin value = 4'd7;      err = 1'b0; end
      SEG_8:     begin value = 4'd8;      err = 1'b0; end
      SEG_9:     begin value = 4'd9;      err = 1'b0; end
      SEG_BLANK: begin value = VAL_BLANK; err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment display bus, captures each digit once it has
// been stable long enough, and presents whole frames over a valid/ready port.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [NUM_DIGITS-1:0] an_q, an_prev;
  logic [6:0]            seg_q, seg_prev;
  logic [CW-1:0]         stable_cnt;
  logic                  an_onehot, sample_changed, capture;
  logic [IW-1:0]         active_idx;
  logic [3:0]            dec_value;
  logic                  dec_err;

  logic [3:0]            slot_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] slot_err, captured;
  logic                  frame_complete;

  out_state_e              state, state_next;
  logic                    load, drop;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   digit_err_q;
  logic                    overflow_q;

  assign an_onehot      = $onehot(~an_q);
  assign sample_changed = (an_q != an_prev) || (seg_q != seg_prev);
  // Fires on the single edge where the counter steps up to STABLE_CYCLES.
  assign capture        = an_onehot && !sample_changed &&
                          (stable_cnt == CW'(STABLE_CYCLES - 1));
  assign frame_complete = &captured;

  always_comb begin
    active_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_q[i]) active_idx = IW'(i);
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_q),
    .value   (dec_value),
    .err     (dec_err)
  );

  // Reset state is all-ones: a blank pattern with no digit enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      an_q       <= '1;
      an_prev    <= '1;
      seg_q      <= '1;
      seg_prev   <= '1;
      stable_cnt <= '0;
    end else begin
      an_q     <= bus.an;
      seg_q    <= bus.seg;
      an_prev  <= an_q;
      seg_prev <= seg_q;
      if (sample_changed || !an_onehot)
        stable_cnt <= '0;
      else if (stable_cnt != CW'(STABLE_CYCLES))
        stable_cnt <= stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the slot array is reset explicitly because a reset must discard a
    // partially captured frame, not just its flags.
    if (rst) begin
      captured <= '0;
      slot_err <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) slot_val[i] <= '0;
    end else begin
      if (frame_complete) captured <= '0;
      if (capture) begin
        slot_val[active_idx] <= dec_value;
        slot_err[active_idx] <= dec_err;
        captured[active_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (frame_complete) begin
          load       = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        // A frame completing while the held one is unaccepted is lost.
        if (frame_complete) begin
          if (bus.frame_ready) load = 1'b1;
          else                 drop = 1'b1;
        end else if (bus.frame_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q    <= '0;
      digit_err_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) digits_q[4*i +: 4] <= slot_val[i];
        digit_err_q <= slot_err;
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.frame_valid = (state == ST_FULL);
  assign bus.digits      = digits_q;
  assign bus.digit_err   = digit_err_q;
  assign bus.overflow    = overflow_q;

endmodule
